// File: rtl/cdb_pkg.sv
// Shared types and default widths for the common data bus arbiter.
package cdb_pkg;

    localparam int XLEN      = 32;
    localparam int CDB_TAG_W = 6;

    // One queued FU result at default widths.
    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [CDB_TAG_W-1:0] tag;
    } cdb_entry_t;

    // Broadcast bus as seen by forwarding, wakeup and the register file.
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      result;
        logic [CDB_TAG_W-1:0] tag;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU result queue: DEPTH entries, synchronous flush, head read combinationally.
module cdb_fu_fifo #(
    parameter int EW    = 38,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [EW-1:0] din_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [EW-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][EW-1:0] mem_q;
    logic [PW-1:0]            wr_q, rd_q;
    logic [CW-1:0]            cnt_q;
    logic                     push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    // Ready is judged on the registered count only, so a full queue refuses a push even when popped.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(push_ok);
            rd_q  <= rd_q + PW'(pop_ok);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: an entry is only read once the count says it was written.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among NUM_FU result queues.
// Optional build macro CDB_ARB_PERF_EN adds perf_conflict_cnt (cycles with 2+ non-empty queues).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU    = 4,
    parameter int DATA_W    = XLEN,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_result,
    input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic                           flush,
    output logic                           cdb_valid,
    output logic [DATA_W-1:0]              cdb_result,
    output logic [TAG_W-1:0]               cdb_tag,
    output logic [$clog2(NUM_FU)-1:0]      cdb_src
`ifdef CDB_ARB_PERF_EN
    ,output logic [31:0]                   perf_conflict_cnt
`endif
);
    localparam int SRC_W = $clog2(NUM_FU);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    logic [NUM_FU-1:0]         q_full, q_empty, q_pop;
    entry_t [NUM_FU-1:0]       q_head;
    logic                      grant_vld;
    logic [SRC_W-1:0]          grant_idx;
    logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      cdb_valid_q;
    logic [DATA_W-1:0]         cdb_result_q;
    logic [TAG_W-1:0]          cdb_tag_q;
    logic [SRC_W-1:0]          cdb_src_q;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        cdb_fu_fifo #(.EW(DATA_W + TAG_W), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .push_i  (fu_valid[i]),
            .pop_i   (q_pop[i]),
            .din_i   ({fu_result[i], fu_tag[i]}),
            .full_o  (q_full[i]),
            .empty_o (q_empty[i]),
            .head_o  (q_head[i])
        );
    end

    assign fu_ready = ~q_full;

    // Pick the first non-empty queue at or after rr_ptr; scanning backwards lets the nearest one win.
    always_comb begin
        int s;
        logic [SRC_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        s         = 0;
        cand      = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            s = int'(rr_ptr_q) + k;
            if (s >= NUM_FU) s = s - NUM_FU;
            cand = SRC_W'(s);
            if (!q_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot pop of the winner, and pointer advance past it with wrap at NUM_FU.
    always_comb begin
        q_pop = '0;
        if (grant_vld) q_pop[grant_idx] = 1'b1;
        rr_ptr_d = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Registered broadcast; data/tag/src hold when idle so consumers see stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_result_q <= '0;
            cdb_tag_q    <= '0;
            cdb_src_q    <= '0;
        end else if (flush) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
        end else if (grant_vld) begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= 1'b1;
            cdb_result_q <= q_head[grant_idx].result;
            cdb_tag_q    <= q_head[grant_idx].tag;
            cdb_src_q    <= grant_idx;
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_result = cdb_result_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_src    = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of cycles where two or more queues compete for the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  perf_q <= '0;
        else if (flush)                              perf_q <= '0;
        else if ($countones(~q_empty) >= 2 && perf_q != '1) perf_q <= perf_q + 32'd1;
    end

    assign perf_conflict_cnt = perf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences, and random
// traffic compared against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int N = 4;
    localparam int D = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        fu_valid;
    logic [N-1:0][31:0]  fu_result;
    logic [N-1:0][5:0]   fu_tag;
    logic [N-1:0]        fu_ready;
    logic                flush;
    logic                cdb_valid;
    logic [31:0]         cdb_result;
    logic [5:0]          cdb_tag;
    logic [1:0]          cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]         perf_conflict_cnt;
`endif

    cdb_arbiter #(.NUM_FU(N), .DATA_W(32), .TAG_W(6), .BUF_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fu_valid   (fu_valid),
        .fu_result  (fu_result),
        .fu_tag     (fu_tag),
        .fu_ready   (fu_ready),
        .flush      (flush),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_tag    (cdb_tag),
        .cdb_src    (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,.perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO queue of {result,tag} per FU plus the broadcast state.
    logic [37:0]  mq[N][$];
    int           m_rr;
    logic         m_vld;
    logic [31:0]  m_res;
    logic [5:0]   m_tag;
    logic [1:0]   m_src;
    logic [31:0]  m_perf;
    logic [N-1:0] last_ready;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = 0; m_vld = 0; m_res = 0; m_tag = 0; m_src = 0; m_perf = 0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    task automatic model_edge(input logic [N-1:0] fv, input logic [N-1:0][31:0] res,
                              input logic [N-1:0][5:0] tg, input logic fl);
        logic [N-1:0] rdy;
        logic [37:0]  e;
        int ne, w, c;
        rdy = model_ready();
        if (fl) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_vld = 0; m_perf = 0;
        end else begin
            ne = 0;
            for (int i = 0; i < N; i++) if (mq[i].size() > 0) ne++;
            if (ne >= 2 && m_perf != 32'hFFFF_FFFF) m_perf++;
            w = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (w < 0 && mq[c].size() > 0) w = c;
            end
            if (w >= 0) begin
                e = mq[w].pop_front();
                m_vld = 1; m_res = e[37:6]; m_tag = e[5:0]; m_src = 2'(w);
                m_rr = (w + 1) % N;
            end else begin
                m_vld = 0;
            end
            for (int i = 0; i < N; i++) if (fv[i] && rdy[i]) mq[i].push_back({res[i], tg[i]});
        end
    endtask

    // One clock: check ready, drive at negedge, advance model at posedge, compare just after.
    task automatic step(input logic [N-1:0] fv, input logic [N-1:0][31:0] res,
                        input logic [N-1:0][5:0] tg, input logic fl);
        @(negedge clk);
        last_ready = fu_ready;
        chk("fu_ready", fu_ready, model_ready());
        fu_valid = fv; fu_result = res; fu_tag = tg; flush = fl;
        @(posedge clk);
        model_edge(fv, res, tg, fl);
        #1;
        chk("cdb_valid", cdb_valid, m_vld);
        chk("cdb_result", cdb_result, m_res);
        chk("cdb_tag", cdb_tag, m_tag);
        chk("cdb_src", cdb_src, m_src);
`ifdef CDB_ARB_PERF_EN
        chk("perf_conflict_cnt", perf_conflict_cnt, m_perf);
`endif
    endtask

    task automatic step_base(input logic [N-1:0] fv, input logic [31:0] rb, input logic [5:0] tb,
                             input logic fl);
        logic [N-1:0][31:0] r;
        logic [N-1:0][5:0]  t;
        for (int i = 0; i < N; i++) begin
            r[i] = rb + 32'(i);
            t[i] = tb + 6'(i);
        end
        step(fv, r, t, fl);
    endtask

    task automatic step_rand(input logic [N-1:0] fv, input logic fl);
        logic [N-1:0][31:0] r;
        logic [N-1:0][5:0]  t;
        for (int i = 0; i < N; i++) begin
            r[i] = $urandom;
            t[i] = 6'($urandom);
        end
        step(fv, r, t, fl);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, cdb_valid, 1'b0);
        chk({tag, "_result"}, cdb_result, 32'd0);
        chk({tag, "_tag"}, cdb_tag, 6'd0);
        chk({tag, "_src"}, cdb_src, 2'd0);
        chk({tag, "_ready"}, fu_ready, 4'b1111);
`ifdef CDB_ARB_PERF_EN
        chk({tag, "_perf"}, perf_conflict_cnt, 32'd0);
`endif
    endtask

    typedef struct {
        logic [N-1:0] fv;
        logic [31:0]  rbase;
        logic [5:0]   tbase;
        logic         fl;
        logic [N-1:0] ready;
        logic         vld;
        logic [31:0]  res;
        logic [5:0]   tag;
        logic [1:0]   src;
    } vec_t;

    vec_t tbl[17];
    logic [1:0] prev_src;
    logic       have_prev;

    initial begin
        // Result of FU i = rbase+i, tag = tbase+i; expected columns are after the edge.
        tbl[0]  = '{4'b0100, 32'hDEADBEED, 6'd15, 1'b0, 4'b1111, 1'b0, 32'h0,        6'd0,  2'd0};
        tbl[1]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b1, 32'hDEADBEEF, 6'd17, 2'd2};
        tbl[2]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b0, 32'hDEADBEEF, 6'd17, 2'd2};
        tbl[3]  = '{4'b0000, 32'h0,        6'd0,  1'b1, 4'b1111, 1'b0, 32'hDEADBEEF, 6'd17, 2'd2};
        tbl[4]  = '{4'b1111, 32'd100,      6'd1,  1'b0, 4'b1111, 1'b0, 32'hDEADBEEF, 6'd17, 2'd2};
        tbl[5]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b1, 32'd100,      6'd1,  2'd0};
        tbl[6]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b1, 32'd101,      6'd2,  2'd1};
        tbl[7]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b1, 32'd102,      6'd3,  2'd2};
        tbl[8]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b1, 32'd103,      6'd4,  2'd3};
        tbl[9]  = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b0, 32'd103,      6'd4,  2'd3};
        tbl[10] = '{4'b1111, 32'd200,      6'd10, 1'b0, 4'b1111, 1'b0, 32'd103,      6'd4,  2'd3};
        tbl[11] = '{4'b1111, 32'd300,      6'd20, 1'b0, 4'b1111, 1'b1, 32'd200,      6'd10, 2'd0};
        tbl[12] = '{4'b1111, 32'd400,      6'd30, 1'b0, 4'b0001, 1'b1, 32'd201,      6'd11, 2'd1};
        tbl[13] = '{4'b1111, 32'd500,      6'd50, 1'b1, 4'b0010, 1'b0, 32'd201,      6'd11, 2'd1};
        tbl[14] = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b0, 32'd201,      6'd11, 2'd1};
        tbl[15] = '{4'b0100, 32'd500,      6'd40, 1'b0, 4'b1111, 1'b0, 32'd201,      6'd11, 2'd1};
        tbl[16] = '{4'b0000, 32'h0,        6'd0,  1'b0, 4'b1111, 1'b1, 32'd502,      6'd42, 2'd2};

        rst_n = 1'b0; fu_valid = '0; fu_result = '0; fu_tag = '0; flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Directed vectors: single request, four-way round robin, flush with full queues.
        foreach (tbl[v]) begin
            step_base(tbl[v].fv, tbl[v].rbase, tbl[v].tbase, tbl[v].fl);
            chk($sformatf("vec%0d_ready", v), last_ready, tbl[v].ready);
            chk($sformatf("vec%0d_valid", v), cdb_valid, tbl[v].vld);
            chk($sformatf("vec%0d_result", v), cdb_result, tbl[v].res);
            chk($sformatf("vec%0d_tag", v), cdb_tag, tbl[v].tag);
            chk($sformatf("vec%0d_src", v), cdb_src, tbl[v].src);
        end

        // Backpressure: FU0 holds its result while its queue is full.
        step_base(4'b0000, 32'd0, 6'd0, 1'b1);
        step_base(4'b1110, 32'd600, 6'd1, 1'b0);
        step_base(4'b1111, 32'd610, 6'd5, 1'b0);
        step_base(4'b0001, 32'd620, 6'd9, 1'b0);
        step_base(4'b0001, 32'd630, 6'd13, 1'b0);
        chk("bp_fu0_blocked", last_ready[0], 1'b0);
        step_base(4'b0001, 32'd630, 6'd13, 1'b0);
        chk("bp_fu0_still_blocked", last_ready[0], 1'b0);
        repeat (8) step_base(4'b0000, 32'd0, 6'd0, 1'b0);

        // Fairness: FU1 and FU3 always busy -> grants alternate between them.
        step_base(4'b0000, 32'd0, 6'd0, 1'b1);
        have_prev = 1'b0;
        prev_src = '0;
        for (int c = 0; c < 12; c++) begin
            step_rand(4'b1010, 1'b0);
            if (cdb_valid) begin
                chk("fair_src_in_set", (cdb_src == 2'd1 || cdb_src == 2'd3), 1'b1);
                if (have_prev) chk("fair_alternate", (cdb_src != prev_src), 1'b1);
                prev_src = cdb_src;
                have_prev = 1'b1;
            end
        end

`ifdef CDB_ARB_PERF_EN
        // Ten cycles with several queues busy, then flush clears the counter.
        step_base(4'b0000, 32'd0, 6'd0, 1'b1);
        step_base(4'b1111, 32'd700, 6'd1, 1'b0);
        for (int c = 0; c < 10; c++) step_base(4'b1111, 32'd710, 6'd5, 1'b0);
        chk("perf_ten", perf_conflict_cnt, 32'd10);
        step_base(4'b0000, 32'd0, 6'd0, 1'b1);
        chk("perf_flushed", perf_conflict_cnt, 32'd0);
`endif

        // Random traffic with occasional flush and one asynchronous reset mid-run.
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                @(negedge clk);
                fu_valid = '0; flush = 1'b0;
                #1 rst_n = 1'b0;
                #1 check_reset_state("midreset");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step_rand(4'($urandom), ($urandom_range(0, 31) == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", nchk);
        $fatal(1, "timeout");
    end

endmodule
